// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the mc_mem_ctrl memory controller.
// Holds the FSM state enum, default widths and the LED register address.
package mc_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [31:0] IO_LED_ADDR = 32'hFFFF_FF00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mc_ram.sv
// Single-port RAM: sync write,
// registered read.
module mc_ram #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 32,
  parameter string       INIT_FILE = ""
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mc_mem_ctrl.sv
// Request/ready memory controller: 2**ADDR_W-word RAM, alignment and range
// checks, fixed-latency responses. Ports: clk, clr (sync, active-high), req,
// we, adr, tom -> fromm, ready, err. With MC_MEM_CTRL_IO_EN defined, adds
// io_in/io_out and an LED register at IO_LED_ADDR.
module mc_mem_ctrl
    import mc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       adr,
    input  logic [DATA_W-1:0] tom,
    output logic [DATA_W-1:0] fromm,
    output logic              ready,
    output logic              err
`ifdef MC_MEM_CTRL_IO_EN
   ,input  logic [15:0]       io_in,
    output logic [15:0]       io_out
`endif
);

`ifdef MC_MEM_CTRL_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    state_e              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [DATA_W-1:0]   data_q;
    logic                io_q;
    logic [DATA_W-1:0]   fromm_q;
    logic                ready_q;
    logic                err_q;
    logic [DATA_W-1:0]   ram_rdata;
    logic                ram_we;
    logic                ram_re;

`ifdef MC_MEM_CTRL_IO_EN
    logic [15:0]         io_out_q;
    logic [15:0]         io_in_q;
`endif

    // Address decode on the live request; only used in IDLE.
    logic adr_aligned;
    logic adr_in_ram;
    logic adr_is_io;
    logic adr_bad;

    always_comb begin
        adr_aligned = (adr[1:0] == 2'b00);
        adr_in_ram  = (adr[31:ADDR_W+2] == '0);
        adr_is_io   = IO_EN && (adr == IO_LED_ADDR);
        adr_bad     = !adr_aligned || (!adr_in_ram && !adr_is_io);
    end

    // clr gates the write strobe so a WRITE edge under reset is dropped.
    assign ram_we = (state_q == ST_WRITE) && !io_q && !clr;
    assign ram_re = (state_q == ST_RD_ADDR) && !io_q;

    mc_ram #(
        .AW        (ADDR_W),
        .DW        (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (idx_q),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            io_q    <= 1'b0;
            fromm_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef MC_MEM_CTRL_IO_EN
            io_out_q <= '0;
            io_in_q  <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        idx_q  <= adr[ADDR_W+1:2];
                        data_q <= tom;
                        io_q   <= adr_is_io;
                        if (adr_bad) begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (we) begin
                            state_q <= ST_WRITE;
                        end else begin
                            state_q <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WRITE: begin
`ifdef MC_MEM_CTRL_IO_EN
                    if (io_q) begin
                        io_out_q <= data_q[15:0];
                    end
`endif
                    state_q <= ST_DONE;
                    ready_q <= 1'b1;
                end
                ST_RD_ADDR: begin
`ifdef MC_MEM_CTRL_IO_EN
                    io_in_q <= io_in;
`endif
                    state_q <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
`ifdef MC_MEM_CTRL_IO_EN
                    if (io_q) begin
                        fromm_q <= DATA_W'(io_in_q);
                    end else begin
                        fromm_q <= ram_rdata;
                    end
`else
                    fromm_q <= ram_rdata;
`endif
                    state_q <= ST_DONE;
                    ready_q <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fromm = fromm_q;
    assign ready = ready_q;
    assign err   = err_q;
`ifdef MC_MEM_CTRL_IO_EN
    assign io_out = io_out_q;
`endif

endmodule

// File: tb/tb_mc_mem_ctrl.sv
// Self-checking bench for mc_mem_ctrl: directed vector table, hand-written
// reset/back-to-back sequences and randomized accesses against a model.
module tb_mc_mem_ctrl;

    localparam logic [31:0] RAM_BYTES = 32'd1024;
    localparam logic [31:0] LED_ADR   = 32'hFFFF_FF00;
`ifdef MC_MEM_CTRL_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] tom;
    logic [31:0] fromm;
    logic        ready;
    logic        err;
`ifdef MC_MEM_CTRL_IO_EN
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic [15:0] io_out_m;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [256];
    logic [31:0] fromm_m;

    always #5 clk = ~clk;

    mc_mem_ctrl dut (
        .clk    (clk),
        .clr    (clr),
        .req    (req),
        .we     (we),
        .adr    (adr),
        .tom    (tom),
        .fromm  (fromm),
        .ready  (ready),
        .err    (err)
`ifdef MC_MEM_CTRL_IO_EN
       ,.io_in  (io_in),
        .io_out (io_out)
`endif
    );

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        bit          e;
        bit          chk_d;
        logic [31:0] q;
    } vec_t;

    vec_t vecs [13];

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] init_val(int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0103);
    endfunction

    // One access: latency counted in falling edges after the accepting edge.
    task automatic access(input bit w, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output bit e, output logic [31:0] q);
        @(negedge clk);
        req = 1'b1;
        we  = w;
        adr = a;
        tom = d;
        lat = 0;
        e   = 1'b0;
        q   = 'x;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                we  = ~w;
                adr = $urandom;
                tom = $urandom;
            end
            if (ready) begin
                lat = k;
                e   = err;
                q   = fromm;
                break;
            end
        end
        req = 1'b0;
    endtask

    int          lat;
    bit          e;
    logic [31:0] q;

    initial begin
        clr = 1'b1;
        req = 1'b0;
        we  = 1'b0;
        adr = '0;
        tom = '0;
        fromm_m = '0;
`ifdef MC_MEM_CTRL_IO_EN
        io_in    = 16'h00C3;
        io_out_m = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_fromm", fromm, 32'd0);
`ifdef MC_MEM_CTRL_IO_EN
        chk("rst_io_out", 32'(io_out), 32'd0);
`endif
        clr = 1'b0;

        for (int i = 0; i < 256; i++) begin
            access(1'b1, 32'(i) << 2, init_val(i), lat, e, q);
            mem_m[i] = init_val(i);
        end
        chk("init_lat", 32'(lat), 32'd2);

        vecs[0]  = '{1, 32'h10, 32'h1234_5678, 2, 0, 0, 32'h0};
        vecs[1]  = '{0, 32'h10, 32'h0, 3, 0, 1, 32'h1234_5678};
        vecs[2]  = '{0, 32'h12, 32'h0, 1, 1, 1, 32'h1234_5678};
        vecs[3]  = '{1, 32'h400, 32'hDEAD_BEEF, 1, 1, 1, 32'h1234_5678};
        vecs[4]  = '{0, 32'h0, 32'h0, 3, 0, 1, init_val(0)};
        vecs[5]  = '{0, 32'h10, 32'h0, 3, 0, 1, 32'h1234_5678};
        vecs[6]  = '{1, 32'h3FC, 32'hCAFE_F00D, 2, 0, 1, 32'h1234_5678};
        vecs[7]  = '{0, 32'h3FC, 32'h0, 3, 0, 1, 32'hCAFE_F00D};
        vecs[8]  = '{0, 32'hFFFF_FFFC, 32'h0, 1, 1, 1, 32'hCAFE_F00D};
`ifdef MC_MEM_CTRL_IO_EN
        vecs[9]  = '{1, LED_ADR, 32'h0000_BEEF, 2, 0, 1, 32'hCAFE_F00D};
        vecs[10] = '{0, LED_ADR, 32'h0, 3, 0, 1, 32'h0000_00C3};
        vecs[11] = '{1, 32'h11, 32'h55, 1, 1, 1, 32'h0000_00C3};
        vecs[12] = '{0, 32'h10, 32'h0, 3, 0, 1, 32'h1234_5678};
`else
        vecs[9]  = '{1, LED_ADR, 32'h0000_BEEF, 1, 1, 1, 32'hCAFE_F00D};
        vecs[10] = '{0, LED_ADR, 32'h0, 1, 1, 1, 32'hCAFE_F00D};
        vecs[11] = '{1, 32'h11, 32'h55, 1, 1, 1, 32'hCAFE_F00D};
        vecs[12] = '{0, 32'h10, 32'h0, 3, 0, 1, 32'h1234_5678};
`endif

        for (int i = 0; i < 13; i++) begin
            access(vecs[i].w, vecs[i].a, vecs[i].d, lat, e, q);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].e));
            if (vecs[i].chk_d) begin
                chk($sformatf("vec%0d_data", i), q, vecs[i].q);
            end
            if (vecs[i].w && !vecs[i].e && vecs[i].a < RAM_BYTES) begin
                mem_m[vecs[i].a[9:2]] = vecs[i].d;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), 32'(ready), 32'd0);
        end
        fromm_m = 32'h1234_5678;
`ifdef MC_MEM_CTRL_IO_EN
        chk("io_out_beef", 32'(io_out), 32'h0000_BEEF);
        io_out_m = 16'hBEEF;
`endif

        // Back-to-back with req held: second access waits out DONE.
        @(negedge clk);
        req = 1'b1;
        we  = 1'b1;
        adr = 32'h4;
        tom = 32'hA;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready) begin
                lat = k;
                break;
            end
        end
        chk("b2b_wr_lat", 32'(lat), 32'd2);
        we  = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready) begin
                lat = k;
                break;
            end
        end
        req = 1'b0;
        chk("b2b_rd_lat", 32'(lat), 32'd4);
        chk("b2b_rd_data", fromm, 32'hA);
        mem_m[1] = 32'hA;
        fromm_m  = 32'hA;

        // Randomized accesses against the model.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            bit          w;
            bit          exp_e;
            bit          is_io;
            int          exp_lat;
            int unsigned r;
            r = $urandom_range(0, 9);
            w = 1'($urandom);
            d = $urandom;
            if (r <= 6) a = 32'($urandom_range(0, 255)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, 255)) << 2) |
                                 32'($urandom_range(1, 3));
            else if (r == 8) a = $urandom | RAM_BYTES;
            else a = LED_ADR;
`ifdef MC_MEM_CTRL_IO_EN
            io_in = 16'($urandom);
`endif
            is_io = IO_EN && (a == LED_ADR);
            exp_e = (a % 4 != 0) || (a >= RAM_BYTES && !is_io);
            exp_lat = exp_e ? 1 : (w ? 2 : 3);
            if (!exp_e) begin
                if (w) begin
`ifdef MC_MEM_CTRL_IO_EN
                    if (is_io) io_out_m = d[15:0];
                    else mem_m[a / 4] = d;
`else
                    mem_m[a / 4] = d;
`endif
                end else begin
`ifdef MC_MEM_CTRL_IO_EN
                    if (is_io) fromm_m = {16'h0, io_in};
                    else fromm_m = mem_m[a / 4];
`else
                    fromm_m = mem_m[a / 4];
`endif
                end
            end
            access(w, a, d, lat, e, q);
            chk($sformatf("rnd%0d_lat a=%08h", n, a), 32'(lat), 32'(exp_lat));
            chk($sformatf("rnd%0d_err a=%08h", n, a), 32'(e), 32'(exp_e));
            chk($sformatf("rnd%0d_data a=%08h", n, a), q, fromm_m);
`ifdef MC_MEM_CTRL_IO_EN
            chk($sformatf("rnd%0d_io_out", n), 32'(io_out), 32'(io_out_m));
`endif
        end

        // Reset during RD_DATA: no ready, fromm cleared.
        @(negedge clk);
        req = 1'b1;
        we  = 1'b0;
        adr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        chk("rstrd_noready_early", 32'(ready), 32'd0);
        clr = 1'b1;
        req = 1'b0;
        @(negedge clk);
        chk("rstrd_ready", 32'(ready), 32'd0);
        chk("rstrd_fromm", fromm, 32'd0);
`ifdef MC_MEM_CTRL_IO_EN
        chk("rstrd_io_out", 32'(io_out), 32'd0);
`endif
        clr = 1'b0;
        @(negedge clk);
        chk("rstrd_ready_after", 32'(ready), 32'd0);

        // Reset on the WRITE edge suppresses the RAM write.
        @(negedge clk);
        req = 1'b1;
        we  = 1'b1;
        adr = 32'h20;
        tom = ~mem_m[8];
        @(negedge clk);
        clr = 1'b1;
        req = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk("rstwr_ready", 32'(ready), 32'd0);
        access(1'b0, 32'h20, 32'h0, lat, e, q);
        chk("rstwr_lat", 32'(lat), 32'd3);
        chk("rstwr_data", q, mem_m[8]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
